// File: rtl/ntt_lane_gather.sv
// ntt_lane_gather: serial-to-parallel front end for the radix-2/4/8 butterfly.
// Each coefficient is reduced once mod Q and written into one of two lane banks.
// A bank that holds a complete group of 8 is presented as 8 parallel lanes.

// Per-lane storage: one register per bank, plus a hold copy of the last
// presented value so the lane output stays quiet while no group is valid.
module ntt_lane_gather_lane #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_bank,
   input  logic             rd_valid,
   output logic [WIDTH-1:0] lane
);
   logic [1:0][WIDTH-1:0] bank_q;
   logic [WIDTH-1:0]      hold_q;

   // bank write and snapshot of whatever is currently being presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '0;
         hold_q <= '0;
      end else begin
         if (wr_en) bank_q[wr_bank] <= wr_data;
         if (rd_valid) hold_q <= bank_q[rd_bank];
      end
   end

   assign lane = rd_valid ? bank_q[rd_bank] : hold_q;
endmodule

module ntt_lane_gather #(
   parameter int WIDTH = 18,
   parameter int Q     = 12289
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       cfg_select_mode,
   input  logic             cfg_ntt_intt_mode,
   input  logic             cfg_bitrev,
   output logic [WIDTH-1:0] out_lane_1,
   output logic [WIDTH-1:0] out_lane_2,
   output logic [WIDTH-1:0] out_lane_3,
   output logic [WIDTH-1:0] out_lane_4,
   output logic [WIDTH-1:0] out_lane_5,
   output logic [WIDTH-1:0] out_lane_6,
   output logic [WIDTH-1:0] out_lane_7,
   output logic [WIDTH-1:0] out_lane_8,
   output logic [1:0]       out_select_mode,
   output logic             out_ntt_intt_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      group_cnt,
   output logic             err_range
);
   localparam int NUM_LANES = 8;
   localparam logic [WIDTH-1:0] QW  = WIDTH'(Q);
   localparam logic [WIDTH:0]   Q2W = (WIDTH+1)'(2 * Q);

   typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_st_e;

   typedef struct packed {
      bank_st_e   st;
      logic [2:0] fill;
      logic [1:0] sel;
      logic       intt;
      logic       bitrev;
   } bank_t;

   bank_t [1:0] bank_q;
   logic        wptr, rptr;
   logic [1:0]  sel_hold_q;
   logic        intt_hold_q;

   logic             accept, consume, first_word, use_br;
   logic [2:0]       fill_k, lane_idx;
   logic [WIDTH-1:0] reduced;
   logic             over_range;
   logic [NUM_LANES-1:0][WIDTH-1:0] lane_q;

   // handshake depends on registered bank state only
   assign in_ready  = (bank_q[wptr].st != FULL);
   assign out_valid = (bank_q[rptr].st == FULL);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   // word 0 uses the live bitrev input, later words the captured one
   assign fill_k     = bank_q[wptr].fill;
   assign first_word = (fill_k == 3'd0);
   assign use_br     = first_word ? cfg_bitrev : bank_q[wptr].bitrev;
   assign lane_idx   = use_br ? {fill_k[0], fill_k[1], fill_k[2]} : fill_k;

   // single conditional subtraction; anything at or above 2Q is flagged
   assign reduced    = (in_data >= QW) ? in_data - QW : in_data;
   assign over_range = ({1'b0, in_data} >= Q2W);

   genvar i;
   generate
      for (i = 0; i < NUM_LANES; i++) begin : g_lane
         ntt_lane_gather_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (accept && (lane_idx == 3'(i))),
            .wr_bank  (wptr),
            .wr_data  (reduced),
            .rd_bank  (rptr),
            .rd_valid (out_valid),
            .lane     (lane_q[i])
         );
      end
   endgenerate

   assign out_lane_1 = lane_q[0];
   assign out_lane_2 = lane_q[1];
   assign out_lane_3 = lane_q[2];
   assign out_lane_4 = lane_q[3];
   assign out_lane_5 = lane_q[4];
   assign out_lane_6 = lane_q[5];
   assign out_lane_7 = lane_q[6];
   assign out_lane_8 = lane_q[7];

   assign out_select_mode   = out_valid ? bank_q[rptr].sel  : sel_hold_q;
   assign out_ntt_intt_mode = out_valid ? bank_q[rptr].intt : intt_hold_q;

   // bank state, pointers, group counter and sticky range error;
   // write and consume never hit the same bank, so both may act in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q      <= '0;
         wptr        <= 1'b0;
         rptr        <= 1'b0;
         group_cnt   <= '0;
         err_range   <= 1'b0;
         sel_hold_q  <= '0;
         intt_hold_q <= 1'b0;
      end else begin
         if (out_valid) begin
            sel_hold_q  <= bank_q[rptr].sel;
            intt_hold_q <= bank_q[rptr].intt;
         end
         if (consume) begin
            bank_q[rptr].st <= EMPTY;
            rptr            <= ~rptr;
            group_cnt       <= group_cnt + 16'd1;
         end
         if (accept) begin
            if (over_range) err_range <= 1'b1;
            if (first_word) begin
               bank_q[wptr].sel    <= cfg_select_mode;
               bank_q[wptr].intt   <= cfg_ntt_intt_mode;
               bank_q[wptr].bitrev <= cfg_bitrev;
               bank_q[wptr].st     <= FILLING;
            end
            bank_q[wptr].fill <= fill_k + 3'd1;
            if (fill_k == 3'd7) begin
               bank_q[wptr].st <= FULL;
               wptr            <= ~wptr;
            end
         end
      end
   end
endmodule

// File: tb/tb_ntt_lane_gather.sv
// Bench for ntt_lane_gather: directed steps plus random traffic against a
// group-level queue model of the gather behaviour.
module tb_ntt_lane_gather;
   localparam int W = 18;
   localparam int Q = 12289;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [1:0] cfg_select_mode = '0;
   logic cfg_ntt_intt_mode = 1'b0;
   logic cfg_bitrev = 1'b0;
   logic [W-1:0] out_lane_1, out_lane_2, out_lane_3, out_lane_4;
   logic [W-1:0] out_lane_5, out_lane_6, out_lane_7, out_lane_8;
   logic [1:0] out_select_mode;
   logic out_ntt_intt_mode;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [15:0] group_cnt;
   logic err_range;

   ntt_lane_gather #(.WIDTH(W), .Q(Q)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cfg_select_mode(cfg_select_mode), .cfg_ntt_intt_mode(cfg_ntt_intt_mode),
      .cfg_bitrev(cfg_bitrev),
      .out_lane_1(out_lane_1), .out_lane_2(out_lane_2), .out_lane_3(out_lane_3),
      .out_lane_4(out_lane_4), .out_lane_5(out_lane_5), .out_lane_6(out_lane_6),
      .out_lane_7(out_lane_7), .out_lane_8(out_lane_8),
      .out_select_mode(out_select_mode), .out_ntt_intt_mode(out_ntt_intt_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .group_cnt(group_cnt), .err_range(err_range)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [8*W-1:0] lanes;
      logic [1:0]     sel;
      logic           intt;
   } grp_t;

   grp_t           mq[$];
   logic [8*W-1:0] cur_lanes, last_lanes;
   logic [1:0]     cur_sel, last_sel;
   logic           cur_intt, cur_br, last_intt, m_err;
   int             cur_k;
   logic [15:0]    m_cnt;
   int             brtab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   int n_asrt = 0;
   int n_fail = 0;

   function automatic logic [8*W-1:0] all_lanes();
      return {out_lane_1, out_lane_2, out_lane_3, out_lane_4,
              out_lane_5, out_lane_6, out_lane_7, out_lane_8};
   endfunction

   task automatic model_reset();
      mq.delete();
      cur_lanes = '0; last_lanes = '0; cur_sel = '0; last_sel = '0;
      cur_intt = 0; cur_br = 0; last_intt = 0; m_err = 0; cur_k = 0; m_cnt = '0;
   endtask

   task automatic model_accept(input logic [W-1:0] d, input logic [1:0] sel,
                               input logic intt, input logic br);
      int p;
      int unsigned v;
      if (cur_k == 0) begin
         cur_sel = sel; cur_intt = intt; cur_br = br; cur_lanes = '0;
      end
      p = cur_br ? brtab[cur_k] : cur_k;
      v = d;
      if (v >= 2 * Q) m_err = 1'b1;
      if (v >= Q) v = v - Q;
      cur_lanes[(7 - p) * W +: W] = W'(v);
      cur_k++;
      if (cur_k == 8) begin
         grp_t g;
         g.lanes = cur_lanes; g.sel = cur_sel; g.intt = cur_intt;
         mq.push_back(g);
         cur_k = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("in_ready", in_ready, mq.size() < 2);
      chk("out_valid", out_valid, mq.size() > 0);
      chk("group_cnt", group_cnt, m_cnt);
      chk("err_range", err_range, m_err);
      if (mq.size() > 0) begin
         last_lanes = mq[0].lanes; last_sel = mq[0].sel; last_intt = mq[0].intt;
      end
      chk("lanes", all_lanes(), last_lanes);
      chk("sel_mode", out_select_mode, last_sel);
      chk("intt_mode", out_ntt_intt_mode, last_intt);
   endtask

   // one clock: drive, check pre-edge state, advance model past the edge
   task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] sel,
                       input logic intt, input logic br, input logic ordy, output logic acc);
      logic cons;
      in_valid = v; in_data = d; cfg_select_mode = sel;
      cfg_ntt_intt_mode = intt; cfg_bitrev = br; out_ready = ordy;
      check_all();
      acc  = v && (mq.size() < 2);
      cons = ordy && (mq.size() > 0);
      @(posedge clk); #1;
      if (cons) begin
         void'(mq.pop_front());
         m_cnt++;
      end
      if (acc) model_accept(d, sel, intt, br);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_out_valid", out_valid, 1'b0);
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   logic a;
   int   n_acc;

   initial begin
      model_reset();
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_all();

      // partial group then reset mid-stream
      for (int k = 0; k < 3; k++) step(1, W'(100 + k), 2'b01, 0, 0, 0, a);
      do_reset();

      // linear fill
      for (int k = 0; k < 8; k++) step(1, W'(k + 1), 2'b10, 0, 0, 1, a);
      chk("lin_valid", out_valid, 1'b1);
      chk("lin_lanes", all_lanes(), {18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8});
      chk("lin_sel", out_select_mode, 2'b10);
      step(0, '0, 0, 0, 0, 1, a);
      chk("lin_cnt", group_cnt, 16'd1);

      // bit-reversed fill
      for (int k = 0; k < 8; k++) step(1, W'(k + 10), 2'b00, 0, 1, 0, a);
      chk("br_lanes", all_lanes(),
          {18'd10, 18'd14, 18'd12, 18'd16, 18'd11, 18'd15, 18'd13, 18'd17});
      step(0, '0, 0, 0, 0, 1, a);

      // reduction and range boundary
      do_reset();
      step(1, 18'd24577, 2'b00, 0, 0, 0, a);
      step(1, 18'd12288, 2'b00, 0, 0, 0, a);
      step(1, 18'd12289, 2'b00, 0, 0, 0, a);
      chk("err_24577", err_range, 1'b0);
      step(1, 18'd30000, 2'b00, 0, 0, 0, a);
      chk("err_30000", err_range, 1'b1);
      step(1, 18'd24578, 2'b00, 0, 0, 0, a);
      for (int k = 0; k < 3; k++) step(1, W'(k), 2'b00, 0, 0, 0, a);
      chk("red_lanes", all_lanes(),
          {18'd12288, 18'd12288, 18'd0, 18'd17711, 18'd12289, 18'd0, 18'd1, 18'd2});
      for (int k = 0; k < 2; k++) step(0, '0, 0, 0, 0, 1, a);

      // backpressure: 24 offered, 16 fit
      n_acc = 0;
      for (int k = 0; k < 24; k++) begin
         step(1, W'(200 + n_acc), 2'b01, 0, 0, 0, a);
         if (a) n_acc++;
      end
      chk("bp_accepted", n_acc, 16);
      chk("bp_in_ready", in_ready, 1'b0);
      step(1, W'(200 + n_acc), 2'b01, 0, 0, 1, a);
      chk("bp_reopen", in_ready, 1'b1);
      while (n_acc < 24) begin
         step(1, W'(200 + n_acc), 2'b01, 0, 0, 0, a);
         if (a) n_acc++;
      end
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 0, 1, a);

      // cfg sampled with word 0 only
      for (int k = 0; k < 8; k++) step(1, W'(300 + k), 2'b01, k >= 3, 0, 0, a);
      chk("cfg_intt_g0", out_ntt_intt_mode, 1'b0);
      for (int k = 0; k < 8; k++) step(1, W'(400 + k), 2'b01, 1, 0, (k == 0), a);
      chk("cfg_intt_g1", out_ntt_intt_mode, 1'b1);
      for (int k = 0; k < 2; k++) step(0, '0, 0, 0, 0, 1, a);

      // random traffic with one reset in the middle
      for (int c = 0; c < 600; c++) begin
         logic [W-1:0] d;
         if (c == 300) do_reset();
         d = ($urandom % 16 == 0) ? W'($urandom_range(24578, 262143))
                                  : W'($urandom_range(0, 24577));
         step(($urandom % 4) != 0, d, 2'($urandom), 1'($urandom), 1'($urandom),
              (c % 100 < 50) ? (($urandom % 3) != 0) : (($urandom % 5) == 0), a);
      end
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 0, 1, a);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
